// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, mode constants and default word widths
// common to the SPI master and slave.
package spi_pkg;

  typedef enum logic {
    StIdle,
    StActive
  } spi_state_e;

  // Mode 0: SCK idles low, data sampled on the leading edge.
  localparam bit SpiCpol = 1'b0;
  localparam bit SpiCpha = 1'b0;

  localparam int unsigned SpiWordBits = 8;

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser for an asynchronous input, plus one edge-detect flop providing
// single-cycle rise/fall strobes of the synchronised value.
module spi_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversamples SCK/CS/MOSI, deserialises MOSI words with a strobe and
// serialises a preloaded word on MISO. Optional sticky overrun under SPI_SLAVE_OVERRUN_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned TO_SPI_BITS   = SpiWordBits,
  parameter int unsigned FROM_SPI_BITS = SpiWordBits,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     spi_clk,
  input  logic                     spi_cs,
  input  logic                     spi_mosi,
  output logic                     spi_miso,
  output logic                     spi_miso_oe,
  input  logic [TO_SPI_BITS-1:0]   tx_data,
  input  logic                     tx_wr,
  output logic                     tx_empty,
  output logic [FROM_SPI_BITS-1:0] rx_data,
  output logic                     rx_stb,
  output logic                     busy,
`ifdef SPI_SLAVE_OVERRUN_EN
  input  logic                     rx_ack,
`endif
  output logic                     rx_overrun
);

  localparam int unsigned TxCntW = (TO_SPI_BITS > 1) ? $clog2(TO_SPI_BITS) : 1;
  localparam int unsigned RxCntW = (FROM_SPI_BITS > 1) ? $clog2(FROM_SPI_BITS) : 1;

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, unused_mosi_rise, unused_mosi_fall;
  logic sample_edge, shift_edge;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (spi_clk),
    .q      (sck_s),
    .rise   (sck_rise),
    .fall   (sck_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (spi_cs),
    .q      (cs_s),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (spi_mosi),
    .q      (mosi_s),
    .rise   (unused_mosi_rise),
    .fall   (unused_mosi_fall)
  );

  // Leading edge samples, trailing edge shifts (swapped when CPOL^CPHA).
  assign sample_edge = (SpiCpol ^ SpiCpha) ? sck_fall : sck_rise;
  assign shift_edge  = (SpiCpol ^ SpiCpha) ? sck_rise : sck_fall;

  spi_state_e               state_q, state_d;
  logic [TO_SPI_BITS-1:0]   tx_hold_q, tx_hold_d;
  logic [TO_SPI_BITS-1:0]   tx_shift_q, tx_shift_d;
  logic [TxCntW-1:0]        tx_cnt_q, tx_cnt_d;
  logic                     tx_empty_q, tx_empty_d;
  logic [FROM_SPI_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [RxCntW-1:0]        rx_cnt_q, rx_cnt_d;
  logic                     rx_done_q, rx_done_d;
  logic [FROM_SPI_BITS-1:0] rx_data_q, rx_data_d;
  logic                     rx_stb_q, rx_stb_d;
  logic                     tx_reload;

  always_comb begin
    state_d    = state_q;
    tx_hold_d  = tx_hold_q;
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_empty_d = tx_empty_q;
    rx_shift_d = rx_shift_q;
    rx_cnt_d   = rx_cnt_q;
    rx_done_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_stb_d   = rx_done_q;
    tx_reload  = 1'b0;

    // A completed word is published one cycle after its last bit lands in rx_shift.
    if (rx_done_q) begin
      rx_data_d = rx_shift_q;
    end

    if (tx_wr) begin
      tx_hold_d  = tx_data;
      tx_empty_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (cs_fall) begin
          state_d   = StActive;
          tx_reload = 1'b1;
          tx_cnt_d  = '0;
          rx_cnt_d  = '0;
        end
      end
      StActive: begin
        if (cs_rise) begin
          state_d  = StIdle;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end else begin
          if (sample_edge) begin
            rx_shift_d = {rx_shift_q[FROM_SPI_BITS-2:0], mosi_s};
            if (rx_cnt_q == RxCntW'(FROM_SPI_BITS - 1)) begin
              rx_cnt_d  = '0;
              rx_done_d = 1'b1;
            end else begin
              rx_cnt_d = rx_cnt_q + RxCntW'(1);
            end
          end
          if (shift_edge) begin
            if (tx_cnt_q == TxCntW'(TO_SPI_BITS - 1)) begin
              tx_reload = 1'b1;
              tx_cnt_d  = '0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
              tx_cnt_d   = tx_cnt_q + TxCntW'(1);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // A write landing on the reload cycle is forwarded and counts as consumed.
    if (tx_reload) begin
      tx_shift_d = tx_wr ? tx_data : tx_hold_q;
      tx_empty_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      tx_cnt_q   <= '0;
      tx_empty_q <= 1'b1;
      rx_shift_q <= '0;
      rx_cnt_q   <= '0;
      rx_done_q  <= 1'b0;
      rx_data_q  <= '0;
      rx_stb_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_hold_q  <= tx_hold_d;
      tx_shift_q <= tx_shift_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_empty_q <= tx_empty_d;
      rx_shift_q <= rx_shift_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_done_q  <= rx_done_d;
      rx_data_q  <= rx_data_d;
      rx_stb_q   <= rx_stb_d;
    end
  end

  logic active;
  // Drop the output enable on the very cycle CS is seen high.
  assign active      = (state_q == StActive) && !cs_s;
  assign spi_miso_oe = active;
  assign spi_miso    = active & tx_shift_q[TO_SPI_BITS-1];
  assign busy        = active;
  assign tx_empty    = tx_empty_q;
  assign rx_data     = rx_data_q;
  assign rx_stb      = rx_stb_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_pend_q, rx_pend_d;
  logic rx_overrun_q, rx_overrun_d;

  always_comb begin
    rx_pend_d    = rx_pend_q;
    rx_overrun_d = rx_overrun_q;
    if (rx_done_q) begin
      rx_pend_d = 1'b1;
    end else if (rx_ack) begin
      rx_pend_d = 1'b0;
    end
    if (rx_done_q && rx_pend_q && !rx_ack) begin
      rx_overrun_d = 1'b1;
    end else if (rx_ack || cs_fall) begin
      rx_overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_pend_q    <= 1'b0;
      rx_overrun_q <= 1'b0;
    end else begin
      rx_pend_q    <= rx_pend_d;
      rx_overrun_q <= rx_overrun_d;
    end
  end

  assign rx_overrun = rx_overrun_q;
`else
  assign rx_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: table of single-word frames plus hand-written multi-word,
// partial-frame, idle-SCK, mid-frame reset and overrun sequences.
module tb_spi_slave;

  localparam int SYNC = 2;
  localparam int HALF = 25;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       spi_clk = 1'b0;
  logic       spi_cs = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       tx_empty;
  logic [7:0] rx_data;
  logic       rx_stb;
  logic       busy;
  logic       rx_overrun;
  logic       rx_ack = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(
    .TO_SPI_BITS  (8),
    .FROM_SPI_BITS(8),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .spi_clk    (spi_clk),
    .spi_cs     (spi_cs),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .tx_data    (tx_data),
    .tx_wr      (tx_wr),
    .tx_empty   (tx_empty),
    .rx_data    (rx_data),
    .rx_stb     (rx_stb),
    .busy       (busy),
`ifdef SPI_SLAVE_OVERRUN_EN
    .rx_ack     (rx_ack),
`endif
    .rx_overrun (rx_overrun)
  );

  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         rise_cyc = 0;
  int         stb_lat = 0;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_stb) begin
      rx_q.push_back(rx_data);
      stb_lat = cyc - rise_cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_tx(input logic [7:0] v);
    @(negedge clk);
    tx_data = v;
    tx_wr   = 1'b1;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  // Master side of nbits of one word; optionally pulses tx_wr during bit wr_bit.
  task automatic xfer(input logic [7:0] mo, input int nbits, input int wr_bit,
                      input logic [7:0] wr_val, output logic [7:0] mi);
    mi = 8'h00;
    for (int b = 0; b < nbits; b++) begin
      spi_mosi = mo[7-b];
      for (int c = 0; c < HALF; c++) begin
        @(negedge clk);
        if (b == wr_bit && c == 2) begin
          tx_data = wr_val;
          tx_wr   = 1'b1;
        end else begin
          tx_wr = 1'b0;
        end
      end
      mi       = {mi[6:0], spi_miso};
      spi_clk  = 1'b1;
      rise_cyc = cyc;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_high();
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(HALF);
  endtask

  typedef struct {
    logic [7:0] mosi;
    logic [7:0] tx;
    logic [7:0] exp_rx;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] mi;
  logic [7:0] mi3[3];

  initial begin
    vecs[0] = '{mosi: 8'h3C, tx: 8'hA5, exp_rx: 8'h3C, exp_miso: 8'hA5};
    vecs[1] = '{mosi: 8'hFF, tx: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
    vecs[2] = '{mosi: 8'h00, tx: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
    vecs[3] = '{mosi: 8'h81, tx: 8'h7E, exp_rx: 8'h81, exp_miso: 8'h7E};
    vecs[4] = '{mosi: 8'h96, tx: 8'h69, exp_rx: 8'h96, exp_miso: 8'h69};

    // Reset values
    wait_clk(3);
    check("reset miso", 32'(spi_miso), 32'd0);
    check("reset miso_oe", 32'(spi_miso_oe), 32'd0);
    check("reset rx_data", 32'(rx_data), 32'd0);
    check("reset rx_stb", 32'(rx_stb), 32'd0);
    check("reset tx_empty", 32'(tx_empty), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset rx_overrun", 32'(rx_overrun), 32'd0);
    reset_n = 1'b1;
    wait_clk(HALF);

    // Single-word frames from the table
    foreach (vecs[i]) begin
      rx_q.delete();
      write_tx(vecs[i].tx);
      check("tx_empty after tx_wr", 32'(tx_empty), 32'd0);
      cs_low();
      check("busy in frame", 32'(busy), 32'd1);
      check("oe in frame", 32'(spi_miso_oe), 32'd1);
      xfer(vecs[i].mosi, 8, -1, 8'h00, mi);
      cs_high();
      check("rx_stb count", 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check("rx word", 32'(rx_q[0]), 32'(vecs[i].exp_rx));
      check("rx_data held", 32'(rx_data), 32'(vecs[i].exp_rx));
      check("miso word", 32'(mi), 32'(vecs[i].exp_miso));
      check("rx_stb latency", 32'(stb_lat), 32'(SYNC + 2));
      check("tx_empty after frame", 32'(tx_empty), 32'd1);
      check("oe after frame", 32'(spi_miso_oe), 32'd0);
    end

    // Three-word frame, holding register rewritten during word 1
    rx_q.delete();
    write_tx(8'h11);
    cs_low();
    xfer(8'h01, 8, 4, 8'h22, mi3[0]);
    xfer(8'h02, 8, -1, 8'h00, mi3[1]);
    xfer(8'h03, 8, -1, 8'h00, mi3[2]);
    cs_high();
    check("3w stb count", 32'(rx_q.size()), 32'd3);
    if (rx_q.size() == 3) begin
      check("3w rx0", 32'(rx_q[0]), 32'h01);
      check("3w rx1", 32'(rx_q[1]), 32'h02);
      check("3w rx2", 32'(rx_q[2]), 32'h03);
    end
    check("3w miso0", 32'(mi3[0]), 32'h11);
    check("3w miso1", 32'(mi3[1]), 32'h22);
    check("3w miso2", 32'(mi3[2]), 32'h22);

    // Partial frame then a clean frame
    rx_q.delete();
    cs_low();
    xfer(8'hFF, 5, -1, 8'h00, mi);
    wait_clk(HALF);
    spi_cs = 1'b1;
    wait_clk(SYNC + 2);
    check("partial oe drop", 32'(spi_miso_oe), 32'd0);
    wait_clk(HALF);
    check("partial no stb", 32'(rx_q.size()), 32'd0);
    cs_low();
    xfer(8'hF0, 8, -1, 8'h00, mi);
    cs_high();
    check("after partial stb", 32'(rx_q.size()), 32'd1);
    check("after partial rx", 32'(rx_data), 32'hF0);

    // SCK activity with CS high is ignored
    rx_q.delete();
    for (int k = 0; k < 20; k++) begin
      spi_mosi = k[0];
      spi_clk  = ~spi_clk;
      wait_clk(HALF);
    end
    spi_clk = 1'b0;
    wait_clk(HALF);
    check("idle sck no stb", 32'(rx_q.size()), 32'd0);
    check("idle sck oe", 32'(spi_miso_oe), 32'd0);
    check("idle sck busy", 32'(busy), 32'd0);
    cs_low();
    xfer(8'h5A, 8, -1, 8'h00, mi);
    cs_high();
    check("after idle sck rx", 32'(rx_data), 32'h5A);
    check("after idle sck count", 32'(rx_q.size()), 32'd1);

    // Reset pulse after four bits of a frame
    rx_q.delete();
    cs_low();
    xfer(8'hAA, 4, 1, 8'h77, mi);
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset tx_empty", 32'(tx_empty), 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid reset oe", 32'(spi_miso_oe), 32'd0);
    check("mid reset miso", 32'(spi_miso), 32'd0);
    check("mid reset rx_data", 32'(rx_data), 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset tx_empty", 32'(tx_empty), 32'd1);
    wait_clk(2);
    reset_n = 1'b1;
    xfer(8'hAA, 4, -1, 8'h00, mi);
    cs_high();
    check("post-reset tail stb", 32'(rx_q.size()), 32'd0);
    cs_low();
    xfer(8'hC3, 8, -1, 8'h00, mi);
    cs_high();
    check("post-reset rx", 32'(rx_data), 32'hC3);
    check("post-reset miso", 32'(mi), 32'h00);

    // Two words with no acknowledge
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    cs_low();
    xfer(8'h12, 8, -1, 8'h00, mi);
    xfer(8'h34, 8, -1, 8'h00, mi);
    cs_high();
`ifdef SPI_SLAVE_OVERRUN_EN
    check("overrun set", 32'(rx_overrun), 32'd1);
`else
    check("overrun tied low", 32'(rx_overrun), 32'd0);
`endif
    check("overrun rx_data", 32'(rx_data), 32'h34);
    rx_ack = 1'b1;
    wait_clk(1);
    rx_ack = 1'b0;
    wait_clk(1);
    check("overrun after ack", 32'(rx_overrun), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
